// File: rtl/int_arbiter.sv
// Interrupt arbiter between NUM_SRC external sources and the multicycle CPU control FSM.
// Synchronises, latches, masks and prioritises sources, then runs a req/ack/eret handshake.
module int_arbiter #(
    parameter int                   NUM_SRC     = 4,
    parameter int                   CAUSE_W     = 5,
    parameter logic [CAUSE_W-1:0]   CAUSE_BASE  = 5'd8,
    parameter logic [NUM_SRC-1:0]   EDGE_MASK   = 4'b0011,
    parameter logic [NUM_SRC-1:0]   MASK_RST    = 4'b0000,
    parameter int                   SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    output logic [NUM_SRC-1:0] mask_out,
    output logic [NUM_SRC-1:0] pend_out,
    input  logic               at_fetch,
    output logic               int_req,
    input  logic               int_ack,
    output logic [CAUSE_W-1:0] int_cause,
    output logic               int_active,
    input  logic               eret
);

    // state   | meaning
    // IDLE    | no request outstanding; raise one when a source is eligible at fetch
    // REQ     | int_req held with int_cause; waiting for int_ack
    // SERVICE | handler running; waiting for eret, no nesting
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    state_t                                 state;
    logic [IDX_W-1:0]                       idx;
    logic [SYNC_STAGES-1:0][NUM_SRC-1:0]    sync_q;
    logic [NUM_SRC-1:0]                     s_out;
    logic [NUM_SRC-1:0]                     s_prev;
    logic [NUM_SRC-1:0]                     rise;
    logic [NUM_SRC-1:0]                     ack_clr;
    logic [NUM_SRC-1:0]                     pend;
    logic [NUM_SRC-1:0]                     pend_next;
    logic [NUM_SRC-1:0]                     mask;
    logic [NUM_SRC-1:0]                     eligible;
    logic [IDX_W-1:0]                       win_idx;

    assign s_out    = sync_q[SYNC_STAGES-1];
    assign rise     = s_out & ~s_prev;
    assign eligible = pend & mask;
    assign mask_out = mask;
    assign pend_out = pend;

    // Only edge sources are cleared by the ack; a simultaneous new edge wins over the clear.
    assign ack_clr   = (state == REQ && int_ack) ? (EDGE_MASK & (NUM_SRC'(1) << idx)) : '0;
    assign pend_next = (EDGE_MASK & ((pend & ~ack_clr) | rise)) | (~EDGE_MASK & s_out);

    always_comb begin
        win_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) win_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            s_prev <= '0;
            pend   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
            s_prev <= s_out;
            pend   <= pend_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= MASK_RST;
        end else if (mask_we) begin
            mask <= mask_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            int_req    <= 1'b0;
            int_cause  <= '0;
            int_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|eligible && at_fetch) begin
                        idx       <= win_idx;
                        int_cause <= CAUSE_BASE + CAUSE_W'(win_idx);
                        int_req   <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        int_req    <= 1'b0;
                        int_active <= 1'b1;
                        state      <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eret) begin
                        int_active <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    int_req    <= 1'b0;
                    int_active <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: directed handshake scenarios plus random traffic,
// checked every cycle against a behavioural model of the arbiter.
module tb_int_arbiter;

    localparam int         N        = 4;
    localparam int         SYNC     = 2;
    localparam int         BASE     = 8;
    localparam logic [3:0] EDGE     = 4'b0011;
    localparam logic [3:0] MASK_RST = 4'b0000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic [3:0] mask_out;
    logic [3:0] pend_out;
    logic       at_fetch;
    logic       int_req;
    logic       int_ack;
    logic [4:0] int_cause;
    logic       int_active;
    logic       eret;

    int n_checks = 0;
    int n_errors = 0;

    int_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask_out   (mask_out),
        .pend_out   (pend_out),
        .at_fetch   (at_fetch),
        .int_req    (int_req),
        .int_ack    (int_ack),
        .int_cause  (int_cause),
        .int_active (int_active),
        .eret       (eret)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 request outstanding, 2 in service.
    bit [3:0] m_pend, m_mask;
    bit       m_req, m_active;
    int       m_phase, m_src, m_cause;
    bit [3:0] seen[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pend = '0; m_mask = MASK_RST; m_req = 0; m_active = 0;
        m_phase = 0; m_src = 0; m_cause = 0;
        seen.delete();
        for (int k = 0; k <= SYNC; k++) seen.push_back(4'b0);
    endfunction

    function automatic void model_edge();
        bit [3:0] now_lvl, old_lvl, elig, np;
        int win;
        now_lvl = seen[SYNC-1];
        old_lvl = seen[SYNC];
        elig = m_pend & m_mask;
        win = -1;
        for (int i = 0; i < N; i++) if (elig[i] && win < 0) win = i;
        for (int i = 0; i < N; i++) begin
            if (EDGE[i]) begin
                if (now_lvl[i] && !old_lvl[i]) np[i] = 1'b1;
                else if (m_phase == 1 && int_ack && i == m_src) np[i] = 1'b0;
                else np[i] = m_pend[i];
            end else begin
                np[i] = now_lvl[i];
            end
        end
        if (m_phase == 0) begin
            if (win >= 0 && at_fetch) begin
                m_src = win; m_cause = (BASE + win) % 32; m_req = 1; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (int_ack) begin m_req = 0; m_active = 1; m_phase = 2; end
        end else begin
            if (eret) begin m_active = 0; m_phase = 0; end
        end
        if (mask_we) m_mask = mask_wdata;
        m_pend = np;
        seen.push_front(irq_in);
        void'(seen.pop_back());
    endfunction

    task automatic compare_all();
        check_val("int_req", int_req, m_req);
        check_val("int_active", int_active, m_active);
        check_val("int_cause", int_cause, m_cause);
        check_val("pend_out", pend_out, m_pend);
        check_val("mask_out", mask_out, m_mask);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_req(input string tag);
        int k = 0;
        while (int_req !== 1'b1 && k < 20) begin step(); k++; end
        check_val(tag, int_req, 1);
    endtask

    task automatic do_ack();
        int_ack = 1; step(); int_ack = 0;
    endtask

    task automatic do_eret();
        eret = 1; step(); eret = 0;
    endtask

    task automatic write_mask(input logic [3:0] v);
        mask_we = 1; mask_wdata = v; step(); mask_we = 0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1;
        irq_in = 0; mask_we = 0; int_ack = 0; eret = 0;
        #1;
        model_reset();
        check_val({tag, "_req"}, int_req, 0);
        check_val({tag, "_active"}, int_active, 0);
        check_val({tag, "_pend"}, pend_out, 0);
        check_val({tag, "_mask"}, mask_out, MASK_RST);
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        reset = 1; irq_in = 0; mask_we = 0; mask_wdata = 0;
        at_fetch = 1; int_ack = 0; eret = 0;
        model_reset();
        #2;
        compare_all();
        @(negedge clk);
        reset = 0;

        // basic edge source and latency
        write_mask(4'hF);
        irq_in = 4'b0010;
        step();
        step();
        step();
        check_val("lat_early", int_req, 0);
        step();
        check_val("lat_req", int_req, 1);
        check_val("lat_cause", int_cause, 9);
        do_ack();
        check_val("ack_pend1", pend_out[1], 0);
        check_val("ack_active", int_active, 1);
        do_eret();
        check_val("eret_active", int_active, 0);
        irq_in = 0; cycles(4);

        // priority: source 0 before level source 3
        irq_in = 4'b1001;
        wait_req("prio_req0");
        check_val("prio_cause0", int_cause, 8);
        do_ack(); do_eret();
        wait_req("prio_req1");
        check_val("prio_cause1", int_cause, 11);
        irq_in = 0;
        do_ack(); cycles(4); do_eret(); cycles(4);
        check_val("prio_done", int_req, 0);

        // masked edge stays pending, unmask raises request without new edge
        write_mask(4'h0);
        irq_in = 4'b0001;
        cycles(5);
        check_val("mask_pend", pend_out, 4'b0001);
        check_val("mask_noreq", int_req, 0);
        irq_in = 0;
        write_mask(4'h1);
        check_val("unmask_early", int_req, 0);
        step();
        check_val("unmask_req", int_req, 1);
        do_ack(); do_eret();
        write_mask(4'hF);

        // level source held through eret is served again, dropped one is not
        irq_in = 4'b0100;
        wait_req("lvl_req0");
        check_val("lvl_cause0", int_cause, 10);
        do_ack(); do_eret();
        wait_req("lvl_req1");
        check_val("lvl_cause1", int_cause, 10);
        irq_in = 0;
        do_ack(); cycles(4); do_eret(); cycles(5);
        check_val("lvl_norereq", int_req, 0);

        // new edge on the served source in the ack cycle survives the clear
        irq_in = 4'b0001;
        wait_req("col_req0");
        check_val("col_cause0", int_cause, 8);
        irq_in = 0; cycles(3);
        irq_in = 4'b0001; step(); step();
        do_ack();
        check_val("col_pend0", pend_out[0], 1);
        do_eret();
        wait_req("col_req1");
        check_val("col_cause1", int_cause, 8);
        do_ack(); do_eret();
        irq_in = 0; cycles(4);

        // no request while the CPU is not at fetch
        at_fetch = 0;
        irq_in = 4'b0010;
        cycles(6);
        check_val("fetch_hold", int_req, 0);
        at_fetch = 1;
        step();
        check_val("fetch_req", int_req, 1);
        do_ack(); do_eret();
        irq_in = 0; cycles(4);

        // reset while requesting and while in service
        irq_in = 4'b0010;
        wait_req("rst_req_pre");
        do_reset("rst_req");
        write_mask(4'hF);
        irq_in = 4'b0001;
        wait_req("rst_svc_pre");
        do_ack();
        check_val("rst_svc_active", int_active, 1);
        do_reset("rst_svc");
        write_mask(4'hF);

        // stray handshake pulses in IDLE
        cycles(4);
        int_ack = 1; step(); int_ack = 0;
        eret = 1; step(); eret = 0;
        check_val("stray_req", int_req, 0);
        check_val("stray_active", int_active, 0);
        check_val("stray_pend", pend_out, 0);

        // random traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int s;
            if ($urandom_range(0, 5) == 0) begin
                s = $urandom_range(0, N - 1);
                irq_in[s] = ~irq_in[s];
            end
            at_fetch   = ($urandom_range(0, 3) != 0);
            mask_we    = ($urandom_range(0, 31) == 0);
            mask_wdata = 4'($urandom);
            int_ack    = m_req    ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            eret       = m_active ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            step();
        end
        mask_we = 0; int_ack = 0; eret = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
